ysyx_22041412_alu_arb: RTL

YSYX_22041412_ALU_ARB -- requirements
Module: ysyx_22041412_alu_arb

---
 rtl/ysyx_22041412_alu_arb.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ysyx_22041412_alu_arb.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_22041412_alu_arb
// Description : Two-requester round-robin front end for one shared
//               combinational ALU. One op is accepted in IDLE, and its
//               operands are latched. The ALU result is registered in EXEC.
//               The result is then presented on the owner's response channel
//               in RESP until that channel accepts it.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   reqN_valid / reqN_ready     request handshake, N = 0,1
//   reqN_scr1, reqN_scr2        operands (XLEN)
//   reqN_opcode/func3/func7     ALU operation select
//   rspN_valid / rspN_ready     response handshake, N = 0,1
//   rspN_result                 response data, zero when rspN_valid is low
//   alu_scr1/scr2/opcode/func3/func7  drive to the shared ALU (registered)
//   alu_result                  ALU output, same cycle as alu_* drive
//   busy                        high whenever an op is in flight
// ============================================================================
module ysyx_22041412_alu_arb #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_scr1,
  input  logic [XLEN-1:0] req0_scr2,
  input  logic [6:0]      req0_opcode,
  input  logic [2:0]      req0_func3,
  input  logic            req0_func7,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_scr1,
  input  logic [XLEN-1:0] req1_scr2,
  input  logic [6:0]      req1_opcode,
  input  logic [2:0]      req1_func3,
  input  logic            req1_func7,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [XLEN-1:0] rsp0_result,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp1_result,
  output logic [XLEN-1:0] alu_scr1,
  output logic [XLEN-1:0] alu_scr2,
  output logic [6:0]      alu_opcode,
  output logic [2:0]      alu_func3,
  output logic            alu_func7,
  input  logic [XLEN-1:0] alu_result,
  output logic            busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_last_grant;
  logic            r_owner;
  logic [XLEN-1:0] r_scr1;
  logic [XLEN-1:0] r_scr2;
  logic [6:0]      r_opcode;
  logic [2:0]      r_func3;
  logic            r_func7;
  logic [XLEN-1:0] r_result;

  logic            w_grant0;
  logic            w_grant1;
  logic            w_accept;
  logic            w_rsp_ready;

  // When both requesters are valid, the one that was not served last wins.
  // last_grant resets to 1, so requester 0 wins the first contention.
  assign w_grant0 = req0_valid && (!req1_valid || r_last_grant);
  assign w_grant1 = req1_valid && (!req0_valid || !r_last_grant);

  // The state already reads IDLE during reset. The explicit rst_n term keeps
  // ready low while reset is held.
  assign req0_ready = rst_n && (r_state == ST_IDLE) && w_grant0;
  assign req1_ready = rst_n && (r_state == ST_IDLE) && w_grant1;
  assign w_accept   = req0_ready || req1_ready;

  assign w_rsp_ready = r_owner ? rsp1_ready : rsp0_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)    w_state_nxt = ST_EXEC;
      ST_EXEC:                  w_state_nxt = ST_RESP;
      ST_RESP: if (w_rsp_ready) w_state_nxt = ST_IDLE;
      default:                  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operands change only on the accept edge. This keeps the ALU inputs
  // stable for the whole operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_scr1       <= '0;
      r_scr2       <= '0;
      r_opcode     <= '0;
      r_func3      <= '0;
      r_func7      <= 1'b0;
      r_result     <= '0;
    end else begin
      if (w_accept) begin
        r_owner      <= req1_ready;
        r_last_grant <= req1_ready;
        r_scr1       <= req1_ready ? req1_scr1   : req0_scr1;
        r_scr2       <= req1_ready ? req1_scr2   : req0_scr2;
        r_opcode     <= req1_ready ? req1_opcode : req0_opcode;
        r_func3      <= req1_ready ? req1_func3  : req0_func3;
        r_func7      <= req1_ready ? req1_func7  : req0_func7;
      end
      if (r_state == ST_EXEC) begin
        r_result <= alu_result;
      end
    end
  end

  assign alu_scr1   = r_scr1;
  assign alu_scr2   = r_scr2;
  assign alu_opcode = r_opcode;
  assign alu_func3  = r_func3;
  assign alu_func7  = r_func7;

  assign rsp0_valid  = (r_state == ST_RESP) && !r_owner;
  assign rsp1_valid  = (r_state == ST_RESP) &&  r_owner;
  assign rsp0_result = rsp0_valid ? r_result : '0;
  assign rsp1_result = rsp1_valid ? r_result : '0;

  assign busy = (r_state != ST_IDLE);

endmodule

`default_nettype wire
